// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction Fetch stage of the pipeline. Owns the program counter, the
// instruction memory and the IF/ID pipeline register. Decode sends back the
// redirect information: branch target, register jump value and PCSrc. The
// architecture uses a delay slot, so the instruction after a branch or jump
// always executes and there is no flush path.
//
// Before execution starts, the debug unit loads the instruction memory one
// byte at a time, most significant byte first. Fetch stays frozen while the
// loader is enabled. Fetching a HALT opcode stops the stage until the next
// reset.
//
// Ports
//   i_clk, i_reset     clock and asynchronous active-high reset
//   i_dunit_clk_en     debug-unit enable that lets the pipeline advance
//   i_stall            hazard stall; holds the PC and IF/ID
//   i_PCSrc            take the branch to i_branch_target
//   i_jump             J/JAL redirect using the pseudo-direct target
//   i_jump_reg         JR/JALR redirect to i_pc_jsel
//   i_load_en          loader mode enable
//   i_load_valid       i_load_byte is valid this cycle
//   i_load_byte        program byte, big-endian order
//   o_inst, o_pcplus4  IF/ID register contents
//   o_pc               current PC, used for debug readout
//   o_halt             sticky flag, set when HALT is fetched
//   o_imem_full        loader has written every memory word
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int NB_REG       = 32,
  parameter int NB_IMEM_ADDR = 8,
  parameter int NB_BYTE      = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_dunit_clk_en,
  input  logic                i_stall,
  input  logic                i_PCSrc,
  input  logic [NB_REG-1:0]   i_branch_target,
  input  logic                i_jump,
  input  logic                i_jump_reg,
  input  logic [NB_REG-1:0]   i_pc_jsel,
  input  logic                i_load_en,
  input  logic                i_load_valid,
  input  logic [NB_BYTE-1:0]  i_load_byte,
  output logic [NB_REG-1:0]   o_inst,
  output logic [NB_REG-1:0]   o_pcplus4,
  output logic [NB_REG-1:0]   o_pc,
  output logic                o_halt,
  output logic                o_imem_full
);

  localparam int         DEPTH   = 2 ** NB_IMEM_ADDR;
  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic {
    LD_IDLE,
    LD_ASM
  } ld_state_t;

  logic [NB_REG-1:0]       imem [DEPTH];
  logic [NB_REG-1:0]       pc;
  logic [NB_IMEM_ADDR-1:0] idx;
  logic [NB_REG-1:0]       fetch_word;
  logic [NB_REG-1:0]       pc_plus4;
  logic [NB_REG-1:0]       next_pc;
  logic                    fetch_halt;
  logic                    adv;

  ld_state_t               ld_state;
  logic [NB_IMEM_ADDR:0]   wptr;
  logic [1:0]              byte_cnt;
  logic [NB_REG-1:0]       asm_buf;
  logic [NB_REG-1:0]       asm_shifted;
  logic                    byte_take;
  logic                    imem_we;

  // ---------------------------------------------------------------------------
  // Fetch datapath
  // ---------------------------------------------------------------------------
  // The memory is word-addressed. pc[1:0] is ignored and the PC wraps
  // modulo DEPTH.
  assign idx        = pc[NB_IMEM_ADDR+1:2];
  assign fetch_word = imem[idx];
  assign fetch_halt = (fetch_word[NB_REG-1 -: 6] == HALT_OP);
  assign pc_plus4   = pc + NB_REG'(4);
  assign adv        = i_dunit_clk_en & ~i_stall & ~o_halt & ~i_load_en;
  assign o_pc       = pc;

  // The pseudo-direct jump target is built from the instruction that is
  // currently in IF/ID, because that is the jump decode is handling.
  always_comb begin
    next_pc = pc_plus4;
    if (i_jump_reg)
      next_pc = i_pc_jsel;
    else if (i_jump)
      next_pc = {o_pcplus4[NB_REG-1:28], o_inst[25:0], 2'b00};
    else if (i_PCSrc)
      next_pc = i_branch_target;
  end

  // A fetched HALT still enters IF/ID, but the PC stays on the halt
  // address.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc        <= '0;
      o_inst    <= '0;
      o_pcplus4 <= '0;
      o_halt    <= 1'b0;
    end else if (adv) begin
      o_inst    <= fetch_word;
      o_pcplus4 <= pc_plus4;
      if (fetch_halt)
        o_halt <= 1'b1;
      else
        pc <= next_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-serial loader
  // ---------------------------------------------------------------------------
  // Bytes shift in from the bottom, so the first byte received ends up in
  // the most significant byte of the word.
  assign asm_shifted = {asm_buf[NB_REG-NB_BYTE-1:0], i_load_byte};
  assign byte_take   = (ld_state == LD_ASM) & i_load_en & i_load_valid & ~o_imem_full;
  assign imem_we     = byte_take & (byte_cnt == 2'd3);

  // o_imem_full is simply the carry bit of the write pointer.
  assign o_imem_full = wptr[NB_IMEM_ADDR];

  // Reset clears the write pointer but leaves the memory contents alone,
  // so a program that is already loaded survives a reset.
  always_ff @(posedge i_clk) begin
    if (imem_we)
      imem[wptr[NB_IMEM_ADDR-1:0]] <= asm_shifted;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ld_state <= LD_IDLE;
      wptr     <= '0;
      byte_cnt <= '0;
      asm_buf  <= '0;
    end else begin
      case (ld_state)
        LD_IDLE: begin
          if (i_load_en)
            ld_state <= LD_ASM;
        end
        LD_ASM: begin
          if (!i_load_en) begin
            // A partial word is dropped. wptr is kept, so the next load
            // session continues from the same word.
            ld_state <= LD_IDLE;
            byte_cnt <= '0;
            asm_buf  <= '0;
          end else if (byte_take) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              asm_buf  <= '0;
              wptr     <= wptr + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              asm_buf  <= asm_shifted;
            end
          end
        end
        default: ld_state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A behavioural model holds a
// memory array, a byte queue for the loader and a plain-arithmetic PC and
// IF/ID. The model follows every clock edge and every reset.
//
// A negedge process compares the DUT outputs with the model. Directed
// scenarios add hand-computed literal checks, and a randomized run
// exercises redirects, stalls, enables, loads and halts.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam int NB_REG       = 32;
  localparam int NB_IMEM_ADDR = 8;
  localparam int NB_BYTE      = 8;
  localparam int DEPTH        = 2 ** NB_IMEM_ADDR;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_dunit_clk_en = 1'b0;
  logic                i_stall = 1'b0;
  logic                i_PCSrc = 1'b0;
  logic [NB_REG-1:0]   i_branch_target = '0;
  logic                i_jump = 1'b0;
  logic                i_jump_reg = 1'b0;
  logic [NB_REG-1:0]   i_pc_jsel = '0;
  logic                i_load_en = 1'b0;
  logic                i_load_valid = 1'b0;
  logic [NB_BYTE-1:0]  i_load_byte = '0;
  logic [NB_REG-1:0]   o_inst;
  logic [NB_REG-1:0]   o_pcplus4;
  logic [NB_REG-1:0]   o_pc;
  logic                o_halt;
  logic                o_imem_full;

  always #5 i_clk = ~i_clk;

  if_fetch_stage #(
    .NB_REG       (NB_REG),
    .NB_IMEM_ADDR (NB_IMEM_ADDR),
    .NB_BYTE      (NB_BYTE)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_dunit_clk_en  (i_dunit_clk_en),
    .i_stall         (i_stall),
    .i_PCSrc         (i_PCSrc),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_reg      (i_jump_reg),
    .i_pc_jsel       (i_pc_jsel),
    .i_load_en       (i_load_en),
    .i_load_valid    (i_load_valid),
    .i_load_byte     (i_load_byte),
    .o_inst          (o_inst),
    .o_pcplus4       (o_pcplus4),
    .o_pc            (o_pc),
    .o_halt          (o_halt),
    .o_imem_full     (o_imem_full)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] gen_words [DEPTH];

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_inst, m_pc4;
  bit          m_halt, m_full, m_prev_en;
  int          m_wptr;
  logic [7:0]  m_bytes [$];

  always @(posedge i_clk or posedge i_reset) begin
    logic [31:0] w;
    int          widx;
    if (i_reset) begin
      m_pc      = '0;
      m_inst    = '0;
      m_pc4     = '0;
      m_halt    = 1'b0;
      m_full    = 1'b0;
      m_prev_en = 1'b0;
      m_wptr    = 0;
      m_bytes.delete();
    end else begin
      // A byte is accepted only if the loader was already enabled on the
      // previous edge.
      if (m_prev_en) begin
        if (!i_load_en) begin
          m_bytes.delete();
        end else if (i_load_valid && !m_full) begin
          m_bytes.push_back(i_load_byte);
          if (m_bytes.size() == 4) begin
            m_mem[m_wptr] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_wptr++;
            m_bytes.delete();
            if (m_wptr == DEPTH) m_full = 1'b1;
          end
        end
      end
      m_prev_en = i_load_en;

      if (i_dunit_clk_en && !i_stall && !m_halt && !i_load_en) begin
        widx = int'((m_pc / 4) % DEPTH);
        w    = m_mem[widx];
        if (w[31:26] == 6'h3f) begin
          m_halt = 1'b1;
          m_pc4  = m_pc + 4;
          m_inst = w;
        end else begin
          logic [31:0] nxt;
          if (i_jump_reg)   nxt = i_pc_jsel;
          else if (i_jump)  nxt = (m_pc4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) * 4);
          else if (i_PCSrc) nxt = i_branch_target;
          else              nxt = m_pc + 4;
          m_pc4  = m_pc + 4;
          m_inst = w;
          m_pc   = nxt;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: runs on every negedge once the first reset is done.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      checkOutput("pc",        o_pc,              m_pc);
      checkOutput("inst",      o_inst,            m_inst);
      checkOutput("pcplus4",   o_pcplus4,         m_pc4);
      checkOutput("halt",      32'(o_halt),       32'(m_halt));
      checkOutput("imem_full", 32'(o_imem_full),  32'(m_full));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; each one is entered just after a negedge
  // ---------------------------------------------------------------------------
  task automatic applyStimulus(input bit clk_en, input bit stall, input bit pcsrc,
                               input bit jump, input bit jump_reg,
                               input logic [31:0] tgt, input logic [31:0] jsel,
                               input bit load_en, input bit load_valid,
                               input logic [7:0] b);
    i_dunit_clk_en  = clk_en;
    i_stall         = stall;
    i_PCSrc         = pcsrc;
    i_jump          = jump;
    i_jump_reg      = jump_reg;
    i_branch_target = tgt;
    i_pc_jsel       = jsel;
    i_load_en       = load_en;
    i_load_valid    = load_valid;
    i_load_byte     = b;
    @(negedge i_clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1, 0, 0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic startLoad();
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 1, 0, '0);
  endtask

  task automatic endLoad();
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic loadByte(input logic [7:0] b);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 1, 1, b);
  endtask

  task automatic loadWord(input logic [31:0] w);
    loadByte(w[31:24]);
    loadByte(w[23:16]);
    loadByte(w[15:8]);
    loadByte(w[7:0]);
  endtask

  // Reset is raised between clock edges, and the outputs must clear
  // before the next edge arrives.
  task automatic doReset();
    i_dunit_clk_en = 0; i_stall = 0; i_PCSrc = 0; i_jump = 0; i_jump_reg = 0;
    i_load_en = 0; i_load_valid = 0;
    #1 i_reset = 1'b1;
    #1;
    checkOutput("rst_pc",      o_pc,             32'h0);
    checkOutput("rst_inst",    o_inst,           32'h0);
    checkOutput("rst_pcplus4", o_pcplus4,        32'h0);
    checkOutput("rst_halt",    32'(o_halt),      32'h0);
    checkOutput("rst_full",    32'(o_imem_full), 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] w;
    @(negedge i_clk);
    doReset();
    cmp_en = 1'b1;

    // Three-word program ending in HALT.
    startLoad();
    loadWord(32'h2001_0005);
    loadWord(32'h2002_0007);
    loadWord(32'hFC00_0000);
    endLoad();
    checkOutput("t1_full", 32'(o_imem_full), 32'h0);
    run(1);
    checkOutput("t1_inst0", o_inst, 32'h2001_0005);
    checkOutput("t1_pc0",   o_pc,   32'h4);
    run(1);
    checkOutput("t1_inst1", o_inst, 32'h2002_0007);
    checkOutput("t1_pc1",   o_pc,   32'h8);
    run(1);
    checkOutput("t1_inst2", o_inst,      32'hFC00_0000);
    checkOutput("t1_halt",  32'(o_halt), 32'h1);
    run(3);
    checkOutput("t1_pc_hold",   o_pc,   32'h8);
    checkOutput("t1_inst_hold", o_inst, 32'hFC00_0000);

    // A two-cycle stall at pc=0x4.
    doReset();
    run(1);
    checkOutput("t2_pc", o_pc, 32'h4);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 0, 0, 0, '0, '0, 0, 0, '0);
      checkOutput("t2_stall_pc",   o_pc,      32'h4);
      checkOutput("t2_stall_inst", o_inst,    32'h2001_0005);
      checkOutput("t2_stall_pc4",  o_pcplus4, 32'h4);
    end
    run(1);
    checkOutput("t2_resume_pc",   o_pc,   32'h8);
    checkOutput("t2_resume_inst", o_inst, 32'h2002_0007);

    // Fill the whole memory, then send extra bytes that must be ignored.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      if (i < 8 && w[31:26] == 6'h3f) w[31:26] = 6'h08;
      gen_words[i] = w;
    end
    startLoad();
    for (int i = 0; i < DEPTH; i++) loadWord(gen_words[i]);
    checkOutput("t4_full_at_depth", 32'(o_imem_full), 32'h1);
    loadWord(32'hDEAD_BEEF);
    endLoad();
    checkOutput("t4_full_sticky", 32'(o_imem_full), 32'h1);
    run(1);
    checkOutput("t4_word0_kept", o_inst, gen_words[0]);

    // Branch redirect, then jump-register and branch in the same cycle.
    doReset();
    run(2);
    checkOutput("t3_pc8", o_pc, 32'h8);
    applyStimulus(1, 0, 1, 0, 0, 32'h40, '0, 0, 0, '0);
    checkOutput("t3_branch", o_pc, 32'h40);
    applyStimulus(1, 0, 1, 0, 1, 32'h40, 32'h80, 0, 0, '0);
    checkOutput("t3_jr_wins", o_pc, 32'h80);

    // Reset in the middle of a run; the memory contents must survive.
    doReset();
    run(4);
    checkOutput("t6_pc10",   o_pc,        32'h10);
    checkOutput("t6_nohalt", 32'(o_halt), 32'h0);
    doReset();
    run(1);
    checkOutput("t6_imem_kept", o_inst, gen_words[0]);

    // An aborted partial word, followed by a full reload of the same word.
    doReset();
    startLoad();
    loadByte(8'hAA);
    loadByte(8'hBB);
    endLoad();
    startLoad();
    loadWord(32'h1234_5678);
    endLoad();
    run(1);
    checkOutput("t5_reload", o_inst, 32'h1234_5678);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        doReset();
      end else if ($urandom_range(0, 49) == 0) begin
        applyStimulus(0, 0, 0, 0, 0, '0, '0, 1, $urandom_range(0, 1) == 1, 8'($urandom()));
      end else begin
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0, $urandom(), $urandom(),
                      0, 0, '0);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
